ddr3_ib_packer: RTL
===================

DDR3_IB_PACKER -- requirements
Module: ddr3_ib_packer

Interface
REQ-001 Parameter DEPTH_LOG2, default 7, log2 of FIFO depth in 128-bit entries (DEPTH = 128).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous clear of packer and FIFO contents.
REQ-005 pi_we  input  1  host 32-bit write strobe.
REQ-006 pi_data  input  32  host write word.
REQ-007 pi_full  output  1  packer cannot accept a word this cycle.
REQ-008 ib_re  input  1  read request from the DDR write-side controller.
REQ-009 ib_data  output  128  read data, qualified by ib_valid.
REQ-010 ib_valid  output  1  ib_data valid; one cycle per accepted read.
REQ-011 ib_count  output  8  committed 128-bit entries held, 0..DEPTH.
REQ-012 ib_empty  output  1  high when ib_count == 0.
REQ-013 overflow  output  1  sticky; a host word was dropped.
REQ-014 underflow  output  1  sticky; ib_re seen while empty.

Function
REQ-015 The packer SHALL hold a 2-bit lane index and three 32-bit lane registers; an accepted word at lane k lands in bits [32k+31:32k].
REQ-016 A word SHALL be accepted when pi_we=1 and pi_full=0 and flush=0; lane index increments mod 4.
REQ-017 On acceptance at lane 3 the SHALL assembled 128-bit word {pi_data, lane2, lane1, lane0} be written to the FIFO on that edge; ib_count reflects it the following cycle.
REQ-018 pi_full SHALL equal (ib_count == DEPTH) && (lane index == 3), computed from registered state only; a simultaneous ib_re does not relieve it.
REQ-019 pi_we while pi_full=1 SHALL drop the word, leave lane index unchanged, and set overflow.
REQ-020 A read SHALL be accepted when ib_re=1, ib_empty=0 and flush=0; ib_data/ib_valid present the oldest entry exactly one cycle later.
REQ-021 ib_re while ib_empty=1 SHALL be ignored (no pointer change, ib_valid low next cycle) and set underflow.
REQ-022 ib_valid SHALL be low in every cycle not following an accepted read; ib_data holds its last value otherwise.
REQ-023 ib_count SHALL update on the edge of the accepting event: +1 for FIFO write only, -1 for read only, unchanged for simultaneous write and read.
REQ-024 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-025 Entries SHALL be read out in write order (strict FIFO).
REQ-026 flush=1 SHALL, on that edge, zero lane index, pointers and ib_count, force ib_valid low, and take priority over pi_we and ib_re; overflow/underflow are unaffected.
REQ-027 FIFO storage SHALL be a simple dual-port array inferable as block RAM; storage contents need not be reset.

Reset
REQ-028 reset_n=0 SHALL asynchronously force lane index 0, pointers 0, ib_count 0, ib_empty 1, ib_valid 0, pi_full 0, overflow 0, underflow 0, ib_data 0.
REQ-029 Reset asserted mid-pack SHALL discard partially packed lanes; the first word after release lands in lane 0.
REQ-030 Outputs SHALL hold reset values until the first rising clk edge after reset_n returns high.

Verification
REQ-031 Write 0x00000001..0x00000004, then pulse ib_re -> ib_count 0->1 the cycle after word 4; next cycle after ib_re ib_valid=1, ib_data=0x00000004_00000003_00000002_00000001, ib_count 0.
REQ-032 Write 3 words, no fourth -> ib_count stays 0, ib_empty 1; ib_re sets underflow, ib_valid stays 0.
REQ-033 Write 512 words (128 entries) then 3 more -> ib_count 128, pi_full 1; 4th extra word dropped, overflow 1; one read -> pi_full 0 next cycle, retried word accepted.
REQ-034 Stream 1024 words while reading continuously -> all 256 entries read out in order, ib_count never exceeds 128, pointers wrap twice, no overflow/underflow.
REQ-035 Simultaneous lane-3 write and read with ib_count=5 -> ib_count stays 5, ib_valid 1 next cycle.
REQ-036 Assert flush with 2 lanes packed and ib_count 10 -> next cycle ib_count 0, ib_empty 1; following 4 writes form one entry beginning at lane 0.

Source files
------------

// File: rtl/ddr3_ib_packer.sv
// Packs 32-bit host words into 128-bit entries and buffers them in a FIFO
// for the DDR write-side controller, with a one-cycle registered read port.
module ddr3_ib_packer #(
  parameter int DEPTH_LOG2 = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         pi_we,
  input  logic [31:0]  pi_data,
  output logic         pi_full,
  input  logic         ib_re,
  output logic [127:0] ib_data,
  output logic         ib_valid,
  output logic [7:0]   ib_count,
  output logic         ib_empty,
  output logic         overflow,
  output logic         underflow
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [7:0] DEPTH_CNT = 8'(DEPTH);

  logic [1:0]            lane_reg;
  logic [31:0]           lane_data_reg [3];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [7:0]            count_reg;
  logic [127:0]          data_reg;
  logic                  valid_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic [127:0]          mem [DEPTH];

  logic                  full_int;
  logic                  empty_int;
  logic                  accept;
  logic                  fifo_we;
  logic                  rd_accept;
  logic [127:0]          packed_word;

  // Full only blocks the word that would complete an entry; lanes 0..2 can
  // still be staged while the FIFO is full.
  assign full_int    = (count_reg == DEPTH_CNT) && (lane_reg == 2'd3);
  assign empty_int   = (count_reg == 8'd0);
  assign accept      = pi_we && !full_int && !flush;
  assign fifo_we     = accept && (lane_reg == 2'd3);
  assign rd_accept   = ib_re && !empty_int && !flush;
  assign packed_word = {pi_data, lane_data_reg[2], lane_data_reg[1], lane_data_reg[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        lane_data_reg[i] <= '0;
      end
    end else if (accept && lane_reg != 2'd3) begin
      lane_data_reg[lane_reg] <= pi_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_reg <= 2'd0;
    end else if (flush) begin
      lane_reg <= 2'd0;
    end else if (accept) begin
      lane_reg <= lane_reg + 2'd1;
    end
  end

  // Storage has no reset so it maps onto a simple dual-port block RAM.
  always_ff @(posedge clk) begin
    if (fifo_we) begin
      mem[wr_ptr_reg] <= packed_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= 8'd0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= 8'd0;
    end else begin
      if (fifo_we) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({fifo_we, rd_accept})
        2'b10:   count_reg <= count_reg + 8'd1;
        2'b01:   count_reg <= count_reg - 8'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A write and a read never target the same address in one cycle: a read
  // needs count > 0 and a write at the read address needs count == DEPTH,
  // which is exactly when pi_full blocks the completing word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= rd_accept;
      if (rd_accept) begin
        data_reg <= mem[rd_ptr_reg];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (pi_we && full_int && !flush) begin
        overflow_reg <= 1'b1;
      end
      if (ib_re && empty_int && !flush) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign pi_full   = full_int;
  assign ib_empty  = empty_int;
  assign ib_count  = count_reg;
  assign ib_data   = data_reg;
  assign ib_valid  = valid_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule
